spi_reg_bank: RTL and testbench

// - Parametrised SPI target (mode 0) that drives a bank of NUM_REGS x DATA_W control registers.
// - Successor to the fixed 8-bit mixed-signal control port; generalised to N registers.
// - Adds addressed write/readback and a per-write strobe.
// - Sits between the bidir PMOD SPI pins (cs/mosi/miso/sclk) and the analog/mixed-signal

---
 rtl/spi_reg_bank.sv | 205 ++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
//==============================================================================
// Module      : spi_reg_bank
// Description : SPI mode-0 target driving NUM_REGS x DATA_W control registers,
//               with addressed write, per-write strobe and optional readback
//               (readback path enabled by defining SPI_READBACK_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_reg_bank #(
    parameter int                 NUM_REGS  = 4,
    parameter int                 ADDR_W    = 3,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_cs_i,
    input  logic                         spi_sclk_i,
    input  logic                         spi_mosi_i,
    output logic                         spi_miso_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_strobe_o,
    output logic [ADDR_W-1:0]            wr_addr_o
);

    localparam int c_MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_CNT_W = $clog2(c_MAX_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Two sync stages per pin plus one delayed copy for edge detection
    logic r_cs_s1, r_cs_s2, r_cs_d;
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_mosi_s1, r_mosi_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_d    <= 1'b1;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_cs_s1   <= spi_cs_i;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;
            r_sclk_s1 <= spi_sclk_i;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_mosi_s1 <= spi_mosi_i;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    logic w_cs_fall;
    logic w_sclk_rise;
    assign w_cs_fall   = r_cs_d & ~r_cs_s2;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_wr_strobe;
    logic [ADDR_W-1:0]   r_wr_addr;

    logic [ADDR_W-1:0]   w_addr_next;
    logic [DATA_W-1:0]   w_data_next;
    logic                w_addr_hit;

    assign w_addr_next = ADDR_W'({r_addr, r_mosi_s2});
    assign w_data_next = DATA_W'({r_data, r_mosi_s2});

    always_comb begin
        w_addr_hit = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_addr == ADDR_W'(k)) w_addr_hit = 1'b1;
        end
    end

`ifdef SPI_READBACK_EN
    logic                w_sclk_fall;
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   r_shift;
    logic                r_miso;

    assign w_sclk_fall = r_sclk_d & ~r_sclk_s2;

    // Out-of-range addresses read back as zero
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_addr_next == ADDR_W'(k)) w_rd_val = r_regs[k];
        end
    end

    assign spi_miso_o = r_miso;
`else
    assign spi_miso_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
`ifdef SPI_READBACK_EN
            r_shift     <= '0;
            r_miso      <= 1'b0;
`endif
        end else begin
            r_wr_strobe <= 1'b0;
            if (r_cs_s2) begin
                r_state <= S_IDLE;
`ifdef SPI_READBACK_EN
                r_miso  <= 1'b0;
`endif
            end else if (w_cs_fall) begin
                // A fresh select always restarts the frame, whatever state we were in
                r_state <= S_CMD;
                r_cnt   <= '0;
`ifdef SPI_READBACK_EN
                r_miso  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_rw    <= r_mosi_s2;
                            r_cnt   <= '0;
                            r_state <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr <= w_addr_next;
                            if (r_cnt == c_CNT_W'(ADDR_W - 1)) begin
                                r_cnt   <= '0;
                                r_state <= S_DATA;
`ifdef SPI_READBACK_EN
                                r_shift <= w_rd_val;
`endif
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_sclk_rise) begin
                            r_data <= w_data_next;
                            if (r_cnt == c_CNT_W'(DATA_W - 1)) begin
                                r_state <= S_DONE;
                                if (r_rw && w_addr_hit) begin
                                    for (int k = 0; k < NUM_REGS; k++) begin
                                        if (r_addr == ADDR_W'(k)) r_regs[k] <= w_data_next;
                                    end
                                    r_wr_strobe <= 1'b1;
                                    r_wr_addr   <= r_addr;
                                end
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                        end
`ifdef SPI_READBACK_EN
                        else if (w_sclk_fall) begin
                            r_miso  <= r_shift[DATA_W-1];
                            r_shift <= r_shift << 1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
            assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign wr_strobe_o = r_wr_strobe;
    assign wr_addr_o   = r_wr_addr;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
//==============================================================================
// Module      : tb_spi_reg_bank
// Description : Scoreboard bench for spi_reg_bank; SPI master tasks push
//               expected writes/readbacks, a monitor compares DUT outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_reg_bank;

    localparam time HALF = 80ns;
    localparam time GAP  = 100ns;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_cs_i;
    logic        spi_sclk_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;
    logic [31:0] regs_o;
    logic        wr_strobe_o;
    logic [2:0]  wr_addr_o;

    spi_reg_bank #(
        .NUM_REGS (4),
        .ADDR_W   (3),
        .DATA_W   (8),
        .RESET_VAL(8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_cs_i   (spi_cs_i),
        .spi_sclk_i (spi_sclk_i),
        .spi_mosi_i (spi_mosi_i),
        .spi_miso_o (spi_miso_o),
        .regs_o     (regs_o),
        .wr_strobe_o(wr_strobe_o),
        .wr_addr_o  (wr_addr_o)
    );

    always #5ns clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [10:0] q_wr[$];      // {addr, data} of expected writes
    logic [7:0]  q_rx_exp[$];  // expected shifted-out byte per frame
    logic [7:0]  q_rx[$];      // byte captured by the master per frame
    logic [7:0]  m_regs [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: one pop per strobe and per completed master capture
    always @(negedge clk) begin
        logic [10:0] e;
        logic [7:0]  x;
        logic [7:0]  r;
        if (wr_strobe_o) begin
            total++;
            if (q_wr.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: addr %0d regs %h", wr_addr_o, regs_o);
            end else begin
                e = q_wr.pop_front();
                if (wr_addr_o !== e[10:8] || regs_o[e[10:8]*8 +: 8] !== e[7:0]) begin
                    bad++;
                    $display("FAIL strobe_write: got addr %0d data %h want addr %0d data %h",
                             wr_addr_o, regs_o[e[10:8]*8 +: 8], e[10:8], e[7:0]);
                end
            end
        end
        if (q_rx.size() > 0) begin
            r = q_rx.pop_front();
            x = (q_rx_exp.size() > 0) ? q_rx_exp.pop_front() : 8'hxx;
            total++;
            if (r !== x) begin
                bad++;
                $display("FAIL miso_byte: got %h want %h", r, x);
            end
        end
    end

    function automatic logic [31:0] model_vec();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic frame(input bit rw, input logic [2:0] addr, input logic [7:0] data,
                         input int ndata, output logic [7:0] rx, output logic last_miso);
        logic [11:0] word;
        word = {rw, addr, data};
        rx = '0;
        spi_cs_i = 1'b0;
        #HALF;
        for (int i = 0; i < 4 + ndata; i++) begin
            spi_mosi_i = word[11-i];
            #HALF;
            if (i >= 4) rx[11-i] = spi_miso_o;
            spi_sclk_i = 1'b1;
            #HALF;
            spi_sclk_i = 1'b0;
        end
        #HALF;
        last_miso  = spi_miso_o;
        spi_cs_i   = 1'b1;
        spi_mosi_i = 1'b0;
        #GAP;
    endtask

    task automatic xfer(input bit rw, input logic [2:0] addr, input logic [7:0] data,
                        input logic exp_last);
        logic [7:0] rx;
        logic [7:0] exp_rx;
        logic       lm;
        exp_rx = (RB && addr < 3'd4) ? m_regs[addr[1:0]] : 8'h00;
        if (rw && addr < 3'd4) q_wr.push_back({addr, data});
        frame(rw, addr, data, 8, rx, lm);
        q_rx_exp.push_back(exp_rx);
        q_rx.push_back(rx);
        if (rw && addr < 3'd4) m_regs[addr[1:0]] = data;
        check("miso_done_hold", {31'd0, lm}, {31'd0, exp_last & RB});
        check("miso_after_cs", {31'd0, spi_miso_o}, 32'd0);
        check("regs_after_frame", regs_o, model_vec());
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        logic       lm;
        for (int k = 0; k < 4; k++) m_regs[k] = 8'h00;
        rst_n = 1'b0; spi_cs_i = 1'b1; spi_sclk_i = 1'b0; spi_mosi_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_regs", regs_o, 32'h0);
        check("reset_miso", {31'd0, spi_miso_o}, 32'd0);
        check("reset_strobe", {31'd0, wr_strobe_o}, 32'd0);
        check("reset_wr_addr", {29'd0, wr_addr_o}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #GAP;

        xfer(1'b1, 3'd2, 8'hA5, 1'b0);   // old reg2 = 00
        xfer(1'b0, 3'd2, 8'h00, 1'b1);   // reads A5, LSB 1 held in DONE
        xfer(1'b1, 3'd0, 8'h81, 1'b0);
        xfer(1'b1, 3'd0, 8'h7E, 1'b1);   // old 81 shifted out, LSB 1
        xfer(1'b1, 3'd5, 8'hFF, 1'b0);   // out of range: no strobe
        xfer(1'b0, 3'd5, 8'h00, 1'b0);

        // Aborted write: cs rises after 6 of 8 data bits
        frame(1'b1, 3'd1, 8'h3C, 6, rx, lm);
        check("abort_regs", regs_o, model_vec());
        xfer(1'b1, 3'd1, 8'h3C, 1'b0);

        // Reset during the address phase
        spi_cs_i = 1'b0;
        #HALF;
        for (int i = 0; i < 2; i++) begin
            spi_mosi_i = (i == 0);
            #HALF;
            spi_sclk_i = 1'b1;
            #HALF;
            spi_sclk_i = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        for (int k = 0; k < 4; k++) m_regs[k] = 8'h00;
        check("midframe_reset_regs", regs_o, model_vec());
        check("midframe_reset_miso", {31'd0, spi_miso_o}, 32'd0);
        check("midframe_reset_strobe", {31'd0, wr_strobe_o}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        spi_cs_i = 1'b1;
        spi_mosi_i = 1'b0;
        #GAP;

        xfer(1'b1, 3'd3, 8'h5A, 1'b0);
        xfer(1'b0, 3'd3, 8'h00, 1'b0);   // reads 5A, LSB 0

        repeat (20) @(posedge clk);
        #2;
        check("pending_writes", q_wr.size(), 32'd0);
        check("pending_reads", q_rx.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
